// File: rtl/regfile_dump.sv
// Read-side sequencer for the register file: walks an index range through one
// read port and streams (index, value) words over a valid/ready handshake.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] First,
  input  logic [ADDR_W-1:0] Last,
  input  logic              Abort,
  output logic [ADDR_W-1:0] Rn,
  input  logic [DATA_W-1:0] Rd,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpIdx,
  output logic [DATA_W-1:0] DumpData,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          idx_d   = First;
          last_d  = Last;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          dump_idx_d  = idx_q;
          dump_data_d = Rd;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        // Abort wins over a same-cycle handshake: the word is dropped.
        if (Abort) begin
          state_d = S_IDLE;
        end else if (DumpReady) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign Rn        = idx_q;
  assign DumpValid = (state_q == S_SEND);
  assign DumpIdx   = dump_idx_q;
  assign DumpData  = dump_data_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: per-cycle vector table plus hand-written
// sequences for range wrap, capture timing and mid-dump reset.
module tb_regfile_dump;

  logic        Clock, Resetn, Start, Abort, DumpReady;
  logic [4:0]  First, Last, Rn, DumpIdx;
  logic [31:0] Rd, DumpData;
  logic        DumpValid, Busy, Done;

  logic [31:0] mem [32];
  assign Rd = mem[Rn];

  int checks = 0;
  int failures = 0;

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .First(First), .Last(Last),
    .Abort(Abort), .Rn(Rn), .Rd(Rd), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .DumpIdx(DumpIdx), .DumpData(DumpData), .Busy(Busy), .Done(Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic        ready;
    logic        abort;
    logic        e_valid;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    logic [4:0]  e_rn;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic [4:0] f, logic [4:0] l, logic r, logic a,
                              logic v, logic [4:0] ix, logic [31:0] d, logic [4:0] rn,
                              logic b, logic dn);
    vec_t t;
    t.start = s; t.first = f; t.last = l; t.ready = r; t.abort = a;
    t.e_valid = v; t.e_idx = ix; t.e_data = d; t.e_rn = rn; t.e_busy = b; t.e_done = dn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rn"},    64'(Rn), 64'd0);
    chk({tag, ".valid"}, 64'(DumpValid), 64'd0);
    chk({tag, ".idx"},   64'(DumpIdx), 64'd0);
    chk({tag, ".data"},  64'(DumpData), 64'd0);
    chk({tag, ".busy"},  64'(Busy), 64'd0);
    chk({tag, ".done"},  64'(Done), 64'd0);
  endtask

  int          cyc;
  logic [4:0]  seen[$];
  logic        bad;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[1] = 32'hFFFF_FFFF;
    mem[2] = 32'h1234_5678;
    Resetn = 1'b0; Start = 1'b0; Abort = 1'b0; DumpReady = 1'b0;
    First = '0; Last = '0;
    step(); step();
    chk_all_zero("reset");
    Resetn = 1'b1;

    // Each row: inputs held for one cycle, then outputs after the edge.
    // Two-word dump 1..2 with ready high.
    tbl.push_back(mk(1, 1, 2, 1, 0,  0, 0, 32'h0,         1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 32'hFFFF_FFFF, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 1, 32'hFFFF_FFFF, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 2, 32'h1234_5678, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 2, 32'h1234_5678, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 2, 32'h1234_5678, 2, 0, 0));
    // Single word 5..5 under 3 cycles of backpressure; Start during Done ignored.
    tbl.push_back(mk(1, 5, 5, 0, 0,  0, 2, 32'h1234_5678, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 5, 32'hC0DE_0005, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 5, 32'hC0DE_0005, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 5, 32'hC0DE_0005, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 5, 32'hC0DE_0005, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 5, 32'hC0DE_0005, 5, 1, 1));
    tbl.push_back(mk(1, 9, 9, 1, 0,  0, 5, 32'hC0DE_0005, 5, 0, 0));
    // Start accepted next cycle, then aborted in READ.
    tbl.push_back(mk(1, 7, 7, 1, 0,  0, 5, 32'hC0DE_0005, 7, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 5, 32'hC0DE_0005, 7, 0, 0));
    // 0..31 dump aborted in SEND of word 1 with ready high.
    tbl.push_back(mk(1, 0, 31, 1, 0, 0, 5, 32'hC0DE_0005, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 32'hC0DE_0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 32'hC0DE_0000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 32'hFFFF_FFFF, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 1, 32'hFFFF_FFFF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 1, 32'hFFFF_FFFF, 1, 0, 0));
    // Fresh Start after abort runs normally.
    tbl.push_back(mk(1, 4, 4, 1, 0,  0, 1, 32'hFFFF_FFFF, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 4, 32'hC0DE_0004, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 4, 32'hC0DE_0004, 4, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 4, 32'hC0DE_0004, 4, 0, 0));

    foreach (tbl[i]) begin
      Start = tbl[i].start; First = tbl[i].first; Last = tbl[i].last;
      DumpReady = tbl[i].ready; Abort = tbl[i].abort;
      step();
      bad = (DumpValid !== tbl[i].e_valid) || (DumpIdx !== tbl[i].e_idx) ||
            (DumpData !== tbl[i].e_data) || (Rn !== tbl[i].e_rn) ||
            (Busy !== tbl[i].e_busy) || (Done !== tbl[i].e_done);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL vec%0d: got v=%b idx=%0d data=%h rn=%0d busy=%b done=%b expected v=%b idx=%0d data=%h rn=%0d busy=%b done=%b",
                 i, DumpValid, DumpIdx, DumpData, Rn, Busy, Done,
                 tbl[i].e_valid, tbl[i].e_idx, tbl[i].e_data, tbl[i].e_rn,
                 tbl[i].e_busy, tbl[i].e_done);
      end
    end
    Start = 0; Abort = 0;

    // Wrapping range 30..1: four words in order, Done on the 9th edge.
    Start = 1; First = 30; Last = 1; DumpReady = 1;
    step();
    Start = 0;
    cyc = 1;
    while (!Done && cyc < 40) begin
      if (DumpValid) begin
        seen.push_back(DumpIdx);
        chk("wrap.data", 64'(DumpData), 64'(mem[DumpIdx]));
      end
      step();
      cyc++;
    end
    chk("wrap.done", 64'(Done), 64'd1);
    chk("wrap.cycles", 64'(cyc), 64'd9);
    chk("wrap.count", 64'(seen.size()), 64'd4);
    if (seen.size() == 4) begin
      chk("wrap.idx0", 64'(seen[0]), 64'd30);
      chk("wrap.idx1", 64'(seen[1]), 64'd31);
      chk("wrap.idx2", 64'(seen[2]), 64'd0);
      chk("wrap.idx3", 64'(seen[3]), 64'd1);
    end
    step();
    chk("wrap.idle", 64'(Busy), 64'd0);

    // Register written during READ: the captured word carries the new value.
    Start = 1; First = 3; Last = 3; DumpReady = 0;
    step();
    Start = 0;
    mem[3] = 32'hA5A5_A5A5;
    step();
    chk("cap.valid", 64'(DumpValid), 64'd1);
    chk("cap.idx", 64'(DumpIdx), 64'd3);
    chk("cap.data", 64'(DumpData), 64'hA5A5_A5A5);
    mem[3] = 32'h0;
    step();
    chk("cap.hold", 64'(DumpData), 64'hA5A5_A5A5);
    DumpReady = 1;
    step();
    chk("cap.done", 64'(Done), 64'd1);
    step();

    // Reset mid-dump clears everything and nothing follows.
    Start = 1; First = 10; Last = 20; DumpReady = 1;
    step();
    Start = 0;
    step(); step();
    Resetn = 0;
    step();
    chk_all_zero("mreset");
    Resetn = 1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (DumpValid || Done || Busy) bad = 1'b1;
    end
    chk("mreset.quiet", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Read-side sequencer for the 32×32 register file: on a start command it walks a contiguous range of register indices through one register-file read port and streams each (index, value) pair out over a valid/ready interface. It sits beside the register file in the datapath and drives that file's `Rn1`/`A` read pair (or `Rn2`/`B`). It feeds the debug/trace path that empties register state after a write sequence. It never writes the register file.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register index width (2^ADDR_W registers).

Ports:
- `Clock`, input, 1: single clock; all state updates on the rising edge.
- `Resetn`, input, 1: synchronous, active-low reset, sampled on the rising edge of `Clock`.
- `Start`, input, 1: one-cycle command, accepted only in IDLE.
- `First`, input, ADDR_W: first index of the range; sampled with `Start`.
- `Last`, input, ADDR_W: last index of the range; sampled with `Start`.
- `Abort`, input, 1: terminates a dump in progress.
- `Rn`, output, ADDR_W: read index driven to the register-file read port.
- `Rd`, input, DATA_W: read data from that port; combinational from `Rn`.
- `DumpValid`, output, 1: `DumpIdx`/`DumpData` hold a valid word.
- `DumpReady`, input, 1: consumer accepts the word.
- `DumpIdx`, output, ADDR_W: register index of the current word.
- `DumpData`, output, DATA_W: register value of the current word.
- `Busy`, output, 1: high in every state except IDLE.
- `Done`, output, 1: one-cycle pulse after the last word transfers.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - `Start`=1 latches `First` into the index counter `idx` and `Last` into `last_q`, then moves to READ.
  - `Start` is ignored in every other state.
- READ:
  - Drives `Rn`=`idx`.
  - At the clock edge, captures `Rd` into `DumpData` and `idx` into `DumpIdx`, then moves to SEND.
- SEND:
  - `DumpValid`=1. `DumpIdx` and `DumpData` are held stable until `DumpValid && DumpReady`.
  - On transfer with `idx`==`last_q`: go to DONE.
  - On transfer otherwise: `idx`←`idx`+1 modulo 2^ADDR_W, go to READ.
- DONE: `Done`=1 for exactly one cycle, then IDLE.
- Range wrap: when `First`>`Last` the walk wraps from 31 to 0. Word count is ((`Last`−`First`) mod 32)+1. `First`==`Last` dumps exactly one word.
- `Abort` in READ or SEND: next state is IDLE and `DumpValid` drops.
  - No `Done` pulse.
  - An in-flight word is discarded even if `DumpReady` is high in the same cycle; `Abort` has priority.
  - `Abort` in IDLE or DONE has no effect.
- Register-file writes during a dump are allowed. Each word reflects the file contents at the clock edge that ends its READ cycle.
- `Rn` holds `idx` in all states. It is 0 after reset.

## Timing
- Reset (`Resetn`=0 at an edge, in any state): state IDLE, `idx`=0, `last_q`=0, `Rn`=0, `DumpValid`=0, `DumpIdx`=0, `DumpData`=0, `Busy`=0, `Done`=0. A dump interrupted by reset produces no further words and no `Done`.
- `Start` at edge t: `Busy`=1 from t; READ occupies cycle t..t+1; first `DumpValid`=1 from edge t+1.
- Throughput with `DumpReady` held high: one word per 2 cycles. An N-word dump takes 2N+1 cycles from `Start` to `Done`, inclusive of the DONE cycle.
- Backpressure: each cycle with `DumpReady`=0 in SEND adds one cycle, and outputs do not change.
- `Busy` falls on the edge leaving DONE. A `Start` in the cycle `Done` is high is ignored; `Start` is accepted from the following cycle.

## Test plan
- Preload r1=32'hFFFFFFFF, r2=32'h12345678; `Start` with `First`=1, `Last`=2, `DumpReady`=1 -> words (1, FFFFFFFF) then (2, 12345678), two cycles apart; `Done` pulses 5 cycles after `Start`; `Busy` falls with it.
- `First`=30, `Last`=1 -> indices 30, 31, 0, 1 in order; exactly 4 transfers.
- `First`=`Last`=5, with `DumpReady` low for 3 cycles -> `DumpValid` held with stable (5, r5) for 4 cycles; exactly one transfer, then `Done`.
- `Abort` asserted during SEND of the second word of a 0..31 dump, with `DumpReady`=1 in the same cycle -> that word is not transferred; next cycle IDLE, `Busy`=0, no `Done`; a new `Start` then runs normally.
- `Resetn`=0 for one edge mid-dump -> all outputs 0 on the next cycle; `Start` asserted during `Done` is ignored; r3 written to 32'hA5A5A5A5 during its READ cycle -> dumped value follows the capture-edge rule.
